// File: rtl/led_breathe_pwm.sv
// PWM dimmer for the four blinky LEDs, with a triangular "breathing" duty envelope
// (fade up, hold lit, fade down, hold dark). i_Bypass passes the LED levels through undimmed.
module led_breathe_pwm #(
   parameter int unsigned PWM_BITS   = 8,
   parameter int unsigned STEP_CLKS  = 100000,
   parameter int unsigned HOLD_STEPS = 64
) (
   input  logic                i_Clk,
   input  logic                i_Rst_L,
   input  logic                i_LED_1,
   input  logic                i_LED_2,
   input  logic                i_LED_3,
   input  logic                i_LED_4,
   input  logic                i_Bypass,
   output logic                o_LED_1,
   output logic                o_LED_2,
   output logic                o_LED_3,
   output logic                o_LED_4,
   output logic [PWM_BITS-1:0] o_Duty,
   output logic [1:0]          o_Phase
);

   localparam int unsigned STEP_W = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;
   localparam int unsigned HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
   localparam logic [PWM_BITS-1:0] MAX_DUTY  = '1;
   localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_CLKS - 1);
   localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

   typedef enum logic [1:0] {
      StUp     = 2'd0,
      StHoldHi = 2'd1,
      StDown   = 2'd2,
      StHoldLo = 2'd3
   } phase_t;

   phase_t              state_q;
   logic [3:0]          led_q;
   logic [3:0]          led_out_q;
   logic [3:0]          led_d;
   logic [PWM_BITS-1:0] pwm_cnt_q;
   logic [PWM_BITS-1:0] duty_q;
   logic [PWM_BITS-1:0] duty_active_q;
   logic [STEP_W-1:0]   step_cnt_q;
   logic [HOLD_W-1:0]   hold_cnt_q;
   logic                tick;
   logic                pwm_on;

   assign tick = (step_cnt_q == STEP_LAST);

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         led_q         <= '0;
         pwm_cnt_q     <= '0;
         step_cnt_q    <= '0;
         duty_active_q <= '0;
      end else begin
         led_q      <= {i_LED_4, i_LED_3, i_LED_2, i_LED_1};
         pwm_cnt_q  <= pwm_cnt_q + 1'b1;
         step_cnt_q <= tick ? '0 : step_cnt_q + 1'b1;
         // Reload only at the period boundary so a PWM period never sees two duties.
         if (pwm_cnt_q == MAX_DUTY) begin
            duty_active_q <= duty_q;
         end
      end
   end

   // Envelope: saturation at 0 / MAX_DUTY is by state transition, never by wrapping.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q    <= StUp;
         duty_q     <= '0;
         hold_cnt_q <= '0;
      end else if (tick) begin
         unique case (state_q)
            StUp: begin
               if (duty_q == MAX_DUTY) begin
                  state_q    <= StHoldHi;
                  hold_cnt_q <= '0;
               end else begin
                  duty_q <= duty_q + 1'b1;
               end
            end
            StHoldHi: begin
               if (hold_cnt_q == HOLD_LAST) begin
                  state_q <= StDown;
               end else begin
                  hold_cnt_q <= hold_cnt_q + 1'b1;
               end
            end
            StDown: begin
               if (duty_q == '0) begin
                  state_q    <= StHoldLo;
                  hold_cnt_q <= '0;
               end else begin
                  duty_q <= duty_q - 1'b1;
               end
            end
            StHoldLo: begin
               if (hold_cnt_q == HOLD_LAST) begin
                  state_q <= StUp;
               end else begin
                  hold_cnt_q <= hold_cnt_q + 1'b1;
               end
            end
            default: state_q <= StUp;
         endcase
      end
   end

   assign pwm_on = (pwm_cnt_q < duty_active_q);

   always_comb begin
      led_d = i_Bypass ? led_q : (led_q & {4{pwm_on}});
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         led_out_q <= '0;
      end else begin
         led_out_q <= led_d;
      end
   end

   assign o_LED_1 = led_out_q[0];
   assign o_LED_2 = led_out_q[1];
   assign o_LED_3 = led_out_q[2];
   assign o_LED_4 = led_out_q[3];
   assign o_Duty  = duty_active_q;
   assign o_Phase = state_q;

endmodule
